// File: rtl/next186_io_pkg.sv
// rtl/next186_io_pkg.sv - shared port constants, command codes and sequencer state type
package next186_io_pkg;

    localparam logic [15:0] MAP_BASE_DEFAULT  = 16'h0080;
    localparam logic [15:0] EMS_BASE_DEFAULT  = 16'h0208;
    localparam logic [15:0] CTRL_PORT_DEFAULT = 16'h020C;

    localparam logic [7:0] CMD_INIT_ALL = 8'h01;
    localparam logic [7:0] CMD_INIT_EMS = 8'h02;

    localparam int MAP_LEN = 16;
    localparam int EMS_LEN = 4;

    // Value written into every EMS frame register during the EMS phase
    localparam logic [7:0] EMS_FILL = 8'hFF;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_MAP  = 2'd1,
        SEQ_EMS  = 2'd2
    } seq_state_t;

    // Distance of an I/O address above a port window base (wraps below base)
    function automatic logic [15:0] port_offset(input logic [15:0] addr, input logic [15:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/ems_init_seq.sv
// rtl/ems_init_seq.sv - init sequencer writing the segment map and EMS frame registers
module ems_init_seq
    import next186_io_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start_all,
    input  logic       start_ems,
    output logic       busy,
    output logic [3:0] idx,
    output logic       we,
    output logic       we_ems,
    output logic [7:0] wdata
);

    seq_state_t state;
    logic [3:0] cnt;

    assign idx = cnt;

    // Sequencer FSM; every output is registered so each strobe lines up with its idx/wdata
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= SEQ_IDLE;
            cnt    <= 4'd0;
            busy   <= 1'b0;
            we     <= 1'b0;
            we_ems <= 1'b0;
            wdata  <= 8'h00;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    cnt <= 4'd0;
                    if (start_all) begin
                        state  <= SEQ_MAP;
                        busy   <= 1'b1;
                        we     <= 1'b1;
                        we_ems <= 1'b0;
                        wdata  <= 8'h00;
                    end else if (start_ems) begin
                        state  <= SEQ_EMS;
                        busy   <= 1'b1;
                        we     <= 1'b0;
                        we_ems <= 1'b1;
                        wdata  <= EMS_FILL;
                    end else begin
                        busy   <= 1'b0;
                        we     <= 1'b0;
                        we_ems <= 1'b0;
                        wdata  <= 8'h00;
                    end
                end
                SEQ_MAP: begin
                    if (cnt == 4'(MAP_LEN - 1)) begin
                        state  <= SEQ_EMS;
                        cnt    <= 4'd0;
                        we     <= 1'b0;
                        we_ems <= 1'b1;
                        wdata  <= EMS_FILL;
                    end else begin
                        cnt   <= cnt + 4'd1;
                        wdata <= {4'b0000, cnt + 4'd1};
                    end
                end
                SEQ_EMS: begin
                    if (cnt == 4'(EMS_LEN - 1)) begin
                        state  <= SEQ_IDLE;
                        cnt    <= 4'd0;
                        busy   <= 1'b0;
                        we_ems <= 1'b0;
                        wdata  <= 8'h00;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state  <= SEQ_IDLE;
                    cnt    <= 4'd0;
                    busy   <= 1'b0;
                    we     <= 1'b0;
                    we_ems <= 1'b0;
                    wdata  <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: rtl/ems_port_ctrl.sv
// rtl/ems_port_ctrl.sv - I/O port decode, map/EMS write strobes, readback and init control
module ems_port_ctrl
    import next186_io_pkg::*;
#(
    parameter logic [15:0] MAP_BASE  = MAP_BASE_DEFAULT,
    parameter logic [15:0] EMS_BASE  = EMS_BASE_DEFAULT,
    parameter logic [15:0] CTRL_PORT = CTRL_PORT_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] io_addr,
    input  logic [7:0]  io_wdata,
    input  logic        io_wr,
    input  logic        io_rd,
    output logic        io_sel,
    output logic [7:0]  io_rdata,
    output logic        io_rvalid,
    output logic        busy,
    output logic [3:0]  map_addr,
    output logic [7:0]  map_wdata,
    output logic        map_we,
    output logic        map_we_ems,
    output logic        map_ems_oe,
    input  logic [7:0]  map_rdata
);

    logic [15:0] map_off;
    logic [15:0] ems_off;
    logic        hit_map;
    logic        hit_ems;
    logic        hit_ctrl;
    logic [3:0]  cpu_idx;
    logic        wr_hit;
    logic        rd_hit;
    logic        rd_live;
    logic        start_all;
    logic        start_ems;

    logic        seq_busy;
    logic        seq_we;
    logic        seq_we_ems;
    logic [3:0]  seq_idx;
    logic [7:0]  seq_wdata;

    logic        cpu_we_q;
    logic        cpu_we_ems_q;
    logic [3:0]  cpu_addr_q;
    logic [7:0]  cpu_wdata_q;
    logic        err;

    assign map_off  = port_offset(io_addr, MAP_BASE);
    assign ems_off  = port_offset(io_addr, EMS_BASE);
    assign hit_map  = (map_off < 16'd16);
    assign hit_ems  = ~hit_map & (ems_off < 16'd4);
    assign hit_ctrl = ~hit_map & ~hit_ems & (io_addr == CTRL_PORT);
    assign io_sel   = hit_map | hit_ems | hit_ctrl;

    assign cpu_idx  = hit_map ? io_addr[3:0] : {2'b00, io_addr[1:0]};

    // io_wr wins over io_rd, so a combined strobe is treated purely as a write
    assign wr_hit   = io_wr & io_sel;
    assign rd_hit   = io_rd & ~io_wr & io_sel;
    assign rd_live  = rd_hit & (hit_map | hit_ems) & ~seq_busy & ~RST;

    assign start_all = io_wr & hit_ctrl & ~seq_busy & (io_wdata == CMD_INIT_ALL);
    assign start_ems = io_wr & hit_ctrl & ~seq_busy & (io_wdata == CMD_INIT_EMS);

    assign busy       = seq_busy;
    assign map_we     = cpu_we_q | seq_we;
    assign map_we_ems = cpu_we_ems_q | seq_we_ems;

    ems_init_seq u_seq (
        .clk       (CLK),
        .rst       (RST),
        .start_all (start_all),
        .start_ems (start_ems),
        .busy      (seq_busy),
        .idx       (seq_idx),
        .we        (seq_we),
        .we_ems    (seq_we_ems),
        .wdata     (seq_wdata)
    );

    // CPU write path: one-cycle strobe with latched index/data; writes during init are dropped
    always_ff @(posedge CLK) begin
        if (RST) begin
            cpu_we_q     <= 1'b0;
            cpu_we_ems_q <= 1'b0;
            cpu_addr_q   <= 4'd0;
            cpu_wdata_q  <= 8'h00;
        end else begin
            cpu_we_q     <= io_wr & hit_map & ~seq_busy;
            cpu_we_ems_q <= io_wr & hit_ems & ~seq_busy;
            if (io_wr & (hit_map | hit_ems) & ~seq_busy) begin
                cpu_addr_q  <= cpu_idx;
                cpu_wdata_q <= io_wdata;
            end
        end
    end

    // Read path and sticky error flag; a status read clears err on the edge that captures it
    always_ff @(posedge CLK) begin
        if (RST) begin
            io_rvalid <= 1'b0;
            io_rdata  <= 8'h00;
            err       <= 1'b0;
        end else begin
            io_rvalid <= rd_hit;
            if (rd_hit) begin
                if (hit_ctrl) begin
                    io_rdata <= {6'b000000, err, seq_busy};
                end else if (seq_busy) begin
                    io_rdata <= 8'hFF;
                end else begin
                    io_rdata <= map_rdata;
                end
            end
            if (wr_hit & seq_busy) begin
                err <= 1'b1;
            end else if (rd_hit & hit_ctrl) begin
                err <= 1'b0;
            end
        end
    end

    // Map bus owner: sequencer while busy, else a live read, else the latched CPU write.
    // A pending write strobe is not protected from a read issued in the very next cycle.
    always_comb begin
        map_addr   = cpu_addr_q;
        map_wdata  = cpu_wdata_q;
        map_ems_oe = 1'b0;
        if (seq_busy) begin
            map_addr  = seq_idx;
            map_wdata = seq_wdata;
        end else if (rd_live) begin
            map_addr   = cpu_idx;
            map_ems_oe = hit_ems;
        end
    end

endmodule

// File: tb/tb_ems_port_ctrl.sv
// tb/tb_ems_port_ctrl.sv - self-checking bench for ems_port_ctrl
module tb_ems_port_ctrl;

    logic        CLK;
    logic        RST;
    logic [15:0] io_addr;
    logic [7:0]  io_wdata;
    logic        io_wr;
    logic        io_rd;
    logic        io_sel;
    logic [7:0]  io_rdata;
    logic        io_rvalid;
    logic        busy;
    logic [3:0]  map_addr;
    logic [7:0]  map_wdata;
    logic        map_we;
    logic        map_we_ems;
    logic        map_ems_oe;
    logic [7:0]  map_rdata;

    int checks;
    int errors;
    bit err_m;

    typedef struct packed {
        logic       we;
        logic       we_ems;
        logic [3:0] a;
        logic [7:0] d;
    } strobe_t;

    strobe_t exp_q[$];

    ems_port_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_wr      (io_wr),
        .io_rd      (io_rd),
        .io_sel     (io_sel),
        .io_rdata   (io_rdata),
        .io_rvalid  (io_rvalid),
        .busy       (busy),
        .map_addr   (map_addr),
        .map_wdata  (map_wdata),
        .map_we     (map_we),
        .map_we_ems (map_we_ems),
        .map_ems_oe (map_ems_oe),
        .map_rdata  (map_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic bit in_map(input logic [15:0] a);
        int v;
        v = int'(a);
        return (v >= 128) && (v < 144);
    endfunction

    function automatic bit in_ems(input logic [15:0] a);
        int v;
        v = int'(a);
        return (v >= 520) && (v < 524);
    endfunction

    function automatic bit in_ctrl(input logic [15:0] a);
        return int'(a) == 524;
    endfunction

    // Expected sequencer strobe list: 16 map writes i->i, then 4 EMS writes of FF
    task automatic build_exp(input logic [7:0] cmd);
        exp_q.delete();
        if (cmd == 8'h01) begin
            for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 1'b0, 4'(i), 8'(i)});
        end
        for (int j = 0; j < 4; j++) exp_q.push_back({1'b0, 1'b1, 4'(j), 8'hFF});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_cmd(input logic [7:0] cmd);
        io_addr = 16'h020C; io_wdata = cmd; io_wr = 1'b1; io_rd = 1'b0;
        tick();
        io_wr = 1'b0; io_addr = 16'h0000;
    endtask

    // One idle-state CPU access, checked against the port-level rules
    task automatic do_access(input logic [15:0] a, input logic [7:0] d, input logic wr,
                             input logic rd, input logic [7:0] rv);
        bit        sel;
        bit        is_rd;
        logic [3:0] idx;
        sel   = in_map(a) || in_ems(a) || in_ctrl(a);
        is_rd = rd && !wr && sel;
        idx   = in_map(a) ? 4'(int'(a) - 128) : 4'(int'(a) - 520);
        io_addr = a; io_wdata = d; io_wr = wr; io_rd = rd; map_rdata = rv;
        #3;
        checks++;
        if (io_sel !== sel) begin
            errors++; $display("FAIL io_sel addr=%h got %b exp %b", a, io_sel, sel);
        end
        if (is_rd && (in_map(a) || in_ems(a))) begin
            checks++;
            if ({map_addr, map_ems_oe} !== {idx, 1'(in_ems(a))}) begin
                errors++;
                $display("FAIL rd_bus addr=%h got addr %h oe %b exp addr %h oe %b",
                         a, map_addr, map_ems_oe, idx, in_ems(a));
            end
        end
        tick();
        io_wr = 1'b0; io_rd = 1'b0;
        checks++;
        if ({busy, map_we, map_we_ems} !== {1'b0, 1'(wr && in_map(a)), 1'(wr && in_ems(a))}) begin
            errors++;
            $display("FAIL strobes addr=%h got busy %b we %b we_ems %b exp we %b we_ems %b",
                     a, busy, map_we, map_we_ems, wr && in_map(a), wr && in_ems(a));
        end
        if (wr && (in_map(a) || in_ems(a))) begin
            checks++;
            if ({map_addr, map_wdata} !== {idx, d}) begin
                errors++;
                $display("FAIL wr_bus addr=%h got %h/%h exp %h/%h", a, map_addr, map_wdata, idx, d);
            end
        end
        checks++;
        if (io_rvalid !== is_rd) begin
            errors++; $display("FAIL rvalid addr=%h got %b exp %b", a, io_rvalid, is_rd);
        end
        if (is_rd) begin
            logic [7:0] er;
            er = in_ctrl(a) ? {6'b0, err_m, 1'b0} : rv;
            if (in_ctrl(a)) err_m = 1'b0;
            checks++;
            if (io_rdata !== er) begin
                errors++; $display("FAIL rdata addr=%h got %h exp %h", a, io_rdata, er);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; io_addr = 16'h0000; io_wdata = 8'h00; io_wr = 1'b0; io_rd = 1'b0;
        map_rdata = 8'h00; err_m = 1'b0;
        repeat (3) tick();
        checks++;
        if ({busy, map_we, map_we_ems, map_ems_oe, io_rvalid, io_rdata, map_addr, map_wdata, io_sel} !== '0) begin
            errors++;
            $display("FAIL reset busy %b we %b we_ems %b oe %b rv %b rdata %h addr %h wdata %h sel %b",
                     busy, map_we, map_we_ems, map_ems_oe, io_rvalid, io_rdata, map_addr, map_wdata, io_sel);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_map_write();
        do_access(16'h0085, 8'h1A, 1'b1, 1'b0, 8'h00);
        do_access(16'h0000, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_ems_read();
        do_access(16'h020A, 8'h00, 1'b0, 1'b1, 8'h23);
        do_access(16'h020C, 8'h00, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [7:0]  d;
        logic        wr;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: a = 16'h0080 + 16'($urandom_range(0, 15));
                1: a = 16'h0208 + 16'($urandom_range(0, 3));
                2: a = 16'h020C;
                default: begin
                    a = 16'($urandom);
                    if (in_map(a) || in_ems(a) || in_ctrl(a)) a = 16'h0300;
                end
            endcase
            d  = 8'($urandom);
            if (in_ctrl(a) && (d == 8'h01 || d == 8'h02)) d = 8'h55;
            wr = 1'($urandom);
            do_access(a, d, wr, !wr, 8'($urandom));
            if (wr) do_access(16'h0000, 8'h00, 1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            do_access(16'h0080 + 16'($urandom_range(0, 15)), 8'($urandom), 1'b1, 1'b0, 8'h00);
        do_access(16'h0209, 8'($urandom), 1'b1, 1'b0, 8'h00);
        do_access(16'h0000, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++)
            do_access(16'h0208 + 16'(i), 8'h00, 1'b0, 1'b1, 8'($urandom));
    endtask

    task automatic test_init_all();
        build_exp(8'h01);
        start_cmd(8'h01);
        for (int k = 0; k < 20; k++) begin
            checks++;
            if ({busy, map_we, map_we_ems, map_addr, map_wdata} !== {1'b1, exp_q[k]}) begin
                errors++;
                $display("FAIL init_all cycle %0d got %b%b%b %h/%h exp %h", k,
                         busy, map_we, map_we_ems, map_addr, map_wdata, {1'b1, exp_q[k]});
            end
            tick();
        end
        checks++;
        if ({busy, map_we, map_we_ems} !== 3'b000) begin
            errors++; $display("FAIL init_all_done got %b%b%b exp 000", busy, map_we, map_we_ems);
        end
        tick();
    endtask

    task automatic test_busy_access();
        bit         rv_exp;
        logic [7:0] rd_exp;
        build_exp(8'h01);
        start_cmd(8'h01);
        rv_exp = 1'b0; rd_exp = 8'h00;
        for (int k = 0; k < 20; k++) begin
            checks++;
            if ({busy, map_we, map_we_ems, map_addr, map_wdata} !== {1'b1, exp_q[k]}) begin
                errors++;
                $display("FAIL busy_seq cycle %0d got %b%b%b %h/%h exp %h", k,
                         busy, map_we, map_we_ems, map_addr, map_wdata, {1'b1, exp_q[k]});
            end
            checks++;
            if (io_rvalid !== rv_exp || (rv_exp && io_rdata !== rd_exp)) begin
                errors++;
                $display("FAIL busy_read cycle %0d got %b/%h exp %b/%h", k, io_rvalid, io_rdata, rv_exp, rd_exp);
            end
            rv_exp = 1'b0;
            case (k)
                1: begin io_addr = 16'h020C; io_wdata = 8'h01; io_wr = 1'b1; err_m = 1'b1; end
                2: begin io_addr = 16'h0083; io_wdata = 8'h5A; io_wr = 1'b1; err_m = 1'b1; end
                4: begin io_addr = 16'h020C; io_rd = 1'b1; rv_exp = 1'b1; rd_exp = {6'b0, err_m, 1'b1}; err_m = 1'b0; end
                6: begin io_addr = 16'h0085; io_rd = 1'b1; map_rdata = 8'h3C; rv_exp = 1'b1; rd_exp = 8'hFF; end
                8: begin io_addr = 16'h020A; io_rd = 1'b1; map_rdata = 8'h11; rv_exp = 1'b1; rd_exp = 8'hFF; end
                default: ;
            endcase
            tick();
            io_wr = 1'b0; io_rd = 1'b0; io_addr = 16'h0000;
        end
        checks++;
        if ({busy, map_we, map_we_ems, io_rvalid} !== 4'b0000) begin
            errors++; $display("FAIL busy_done got %b%b%b%b exp 0000", busy, map_we, map_we_ems, io_rvalid);
        end
        do_access(16'h020C, 8'h00, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_reset_abort();
        build_exp(8'h01);
        start_cmd(8'h01);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if ({busy, map_we, map_we_ems, map_addr, map_wdata} !== {1'b1, exp_q[k]}) begin
                errors++;
                $display("FAIL abort_seq cycle %0d got %b%b%b %h/%h exp %h", k,
                         busy, map_we, map_we_ems, map_addr, map_wdata, {1'b1, exp_q[k]});
            end
            if (k == 6) RST = 1'b1;
            tick();
        end
        RST = 1'b0;
        err_m = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({busy, map_we, map_we_ems} !== 3'b000) begin
                errors++; $display("FAIL abort_idle cycle %0d got %b%b%b exp 000", k, busy, map_we, map_we_ems);
            end
            tick();
        end
        build_exp(8'h02);
        start_cmd(8'h02);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({busy, map_we, map_we_ems, map_addr, map_wdata} !== {1'b1, exp_q[k]}) begin
                errors++;
                $display("FAIL init_ems cycle %0d got %b%b%b %h/%h exp %h", k,
                         busy, map_we, map_we_ems, map_addr, map_wdata, {1'b1, exp_q[k]});
            end
            tick();
        end
        checks++;
        if ({busy, map_we, map_we_ems} !== 3'b000) begin
            errors++; $display("FAIL init_ems_done got %b%b%b exp 000", busy, map_we, map_we_ems);
        end
        do_access(16'h020C, 8'h00, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_priority_miss();
        do_access(16'h0081, 8'($urandom), 1'b1, 1'b1, 8'h77);
        do_access(16'h0000, 8'h00, 1'b0, 1'b0, 8'h00);
        do_access(16'h0300, 8'h00, 1'b0, 1'b1, 8'h99);
        do_access(16'h0300, 8'h42, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_map_write();
        test_ems_read();
        test_random();
        test_back_to_back();
        test_init_all();
        test_busy_access();
        test_reset_abort();
        test_priority_miss();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
